// File: rtl/serial_sub_ctrl.sv
// Bit-serial A - B - Bin sequencer driving a single 1-bit full-subtractor, LSB first.
// Optional signed-overflow output is enabled by defining SUB_OVF_EN.
module serial_sub_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
`ifdef SUB_OVF_EN
   output logic             ovf,
`endif
   output logic             bout
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_reg;
   logic [WIDTH-1:0] a_sh_reg;
   logic [WIDTH-1:0] b_sh_reg;
   logic [WIDTH-1:0] r_sh_reg;
   logic             br_reg;
   logic [CW-1:0]    cnt_reg;
`ifdef SUB_OVF_EN
   logic             a_msb_reg;
   logic             b_msb_reg;
`endif

   logic             d_bit;
   logic             bo_bit;
   logic             last_bit;
   logic [WIDTH-1:0] r_next;

   // The shared 1-bit full-subtractor cell and the result shift-in.
   always_comb begin
      d_bit    = a_sh_reg[0] ^ b_sh_reg[0] ^ br_reg;
      bo_bit   = (~a_sh_reg[0] & b_sh_reg[0]) | (~(a_sh_reg[0] ^ b_sh_reg[0]) & br_reg);
      r_next   = (r_sh_reg >> 1) | (WIDTH'(d_bit) << (WIDTH - 1));
      last_bit = (cnt_reg == CW'(WIDTH - 1));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         diff      <= '0;
         bout      <= 1'b0;
         a_sh_reg  <= '0;
         b_sh_reg  <= '0;
         r_sh_reg  <= '0;
         br_reg    <= 1'b0;
         cnt_reg   <= '0;
`ifdef SUB_OVF_EN
         ovf       <= 1'b0;
         a_msb_reg <= 1'b0;
         b_msb_reg <= 1'b0;
`endif
      end else begin
         case (state_reg)
            // DONE accepts a new request exactly like IDLE, so back-to-back runs have no gap.
            IDLE, DONE: begin
               done <= 1'b0;
               if (start) begin
                  a_sh_reg  <= a;
                  b_sh_reg  <= b;
                  br_reg    <= bin;
                  cnt_reg   <= '0;
`ifdef SUB_OVF_EN
                  a_msb_reg <= a[WIDTH-1];
                  b_msb_reg <= b[WIDTH-1];
`endif
                  busy      <= 1'b1;
                  state_reg <= RUN;
               end else begin
                  state_reg <= IDLE;
               end
            end
            RUN: begin
               a_sh_reg <= a_sh_reg >> 1;
               b_sh_reg <= b_sh_reg >> 1;
               r_sh_reg <= r_next;
               br_reg   <= bo_bit;
               cnt_reg  <= cnt_reg + CW'(1);
               if (last_bit) begin
                  diff      <= r_next;
                  bout      <= bo_bit;
`ifdef SUB_OVF_EN
                  ovf       <= (a_msb_reg ^ b_msb_reg) & (r_next[WIDTH-1] ^ a_msb_reg);
`endif
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  state_reg <= DONE;
               end
            end
            default: begin
               busy      <= 1'b0;
               done      <= 1'b0;
               state_reg <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Directed and randomized checks of serial_sub_ctrl at WIDTH=8 against hand-computed results.
// Overflow checks are included when SUB_OVF_EN is defined.
module tb_serial_sub_ctrl;

   localparam int WIDTH = 8;

   logic             clk;
   logic             rst;
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             bin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             bout;
`ifdef SUB_OVF_EN
   logic             ovf;
`endif

   int tests;
   int fails;

   serial_sub_ctrl #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .bin   (bin),
      .busy  (busy),
      .done  (done),
      .diff  (diff),
`ifdef SUB_OVF_EN
      .ovf   (ovf),
`endif
      .bout  (bout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock; outputs are then sampled 1 ns after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a request for exactly one edge.
   task automatic issue(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic bv_in);
      a = av; b = bv; bin = bv_in; start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input string name);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 64; i++) begin
         if (done) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      if (!ok) begin
         tests++; fails++;
         $display("FAIL %s: done not seen within 64 cycles", name);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b1; a = 8'hFF; b = 8'h00; bin = 1'b1;
      tick(); tick();
      rst = 1'b0; start = 1'b0;
      tests++;
      if ({busy, done, diff, bout} !== 11'd0) begin
         fails++;
         $display("FAIL reset: busy=%b done=%b diff=%h bout=%b, required all 0", busy, done, diff, bout);
      end
`ifdef SUB_OVF_EN
      tests++;
      if (ovf !== 1'b0) begin
         fails++;
         $display("FAIL reset_ovf: ovf=%b, required 0", ovf);
      end
`endif
      tick(); tick();
      tests++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         fails++;
         $display("FAIL idle_hold: busy=%b done=%b, required 0 0", busy, done);
      end
      $display("[TB] reset: busy=%b done=%b diff=%h bout=%b", busy, done, diff, bout);
   endtask

   // Full-latency check: busy for WIDTH cycles, done for exactly one.
   task automatic test_basic();
      int busy_bad;
      busy_bad = 0;
      issue(8'h5A, 8'h3C, 1'b0);
      for (int i = 0; i < WIDTH; i++) begin
         if (busy !== 1'b1 || done !== 1'b0) busy_bad++;
         tick();
      end
      tests++;
      if (busy_bad != 0) begin
         fails++;
         $display("FAIL basic_busy: %0d bad busy/done cycles during RUN, required 0", busy_bad);
      end
      tests++;
      if (done !== 1'b1 || busy !== 1'b0) begin
         fails++;
         $display("FAIL basic_done: done=%b busy=%b at cycle WIDTH, required 1 0", done, busy);
      end
      tests++;
      if (diff !== 8'h1E || bout !== 1'b0) begin
         fails++;
         $display("FAIL basic_result: diff=%h bout=%b, required 1e 0", diff, bout);
      end
      $display("[TB] 5a-3c-0: diff=%h bout=%b", diff, bout);
      tick();
      tests++;
      if (done !== 1'b0 || diff !== 8'h1E) begin
         fails++;
         $display("FAIL done_strobe: done=%b diff=%h after strobe, required 0 1e", done, diff);
      end
   endtask

   task automatic test_borrow();
      issue(8'h00, 8'h01, 1'b0);
      wait_done("borrow_wait1");
      tests++;
      if (diff !== 8'hFF || bout !== 1'b1) begin
         fails++;
         $display("FAIL borrow_wrap: diff=%h bout=%b, required ff 1", diff, bout);
      end
      $display("[TB] 00-01-0: diff=%h bout=%b", diff, bout);
      tick();
      issue(8'h10, 8'h0F, 1'b1);
      wait_done("borrow_wait2");
      tests++;
      if (diff !== 8'h00 || bout !== 1'b0) begin
         fails++;
         $display("FAIL borrow_in: diff=%h bout=%b, required 00 0", diff, bout);
      end
      $display("[TB] 10-0f-1: diff=%h bout=%b", diff, bout);
      tick();
   endtask

   // A start during RUN is ignored; a start in DONE is accepted immediately.
   task automatic test_back_to_back();
      int busy_bad;
      busy_bad = 0;
      issue(8'h5A, 8'h3C, 1'b0);
      tick(); tick();
      a = 8'hFF; b = 8'h00; bin = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      wait_done("ignore_wait");
      tests++;
      if (diff !== 8'h1E || bout !== 1'b0) begin
         fails++;
         $display("FAIL ignore_start: diff=%h bout=%b, required 1e 0", diff, bout);
      end
      $display("[TB] 5a-3c-0 with mid-run start: diff=%h bout=%b", diff, bout);
      issue(8'h03, 8'h01, 1'b0);
      tests++;
      if (busy !== 1'b1 || done !== 1'b0 || diff !== 8'h1E) begin
         fails++;
         $display("FAIL b2b_accept: busy=%b done=%b diff=%h, required 1 0 1e", busy, done, diff);
      end
      for (int i = 0; i < WIDTH; i++) begin
         if (busy !== 1'b1) busy_bad++;
         tick();
      end
      tests++;
      if (busy_bad != 0 || done !== 1'b1 || diff !== 8'h02 || bout !== 1'b0) begin
         fails++;
         $display("FAIL b2b_result: busy_bad=%0d done=%b diff=%h bout=%b, required 0 1 02 0",
                  busy_bad, done, diff, bout);
      end
      $display("[TB] 03-01-0 back-to-back: diff=%h bout=%b", diff, bout);
      tick();
   endtask

   task automatic test_abort();
      issue(8'h00, 8'h01, 1'b0);
      wait_done("abort_pre");
      tick();
      issue(8'h5A, 8'h3C, 1'b0);
      for (int i = 0; i < 4; i++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tests++;
      if (busy !== 1'b0 || done !== 1'b0 || diff !== 8'h00 || bout !== 1'b0) begin
         fails++;
         $display("FAIL abort: busy=%b done=%b diff=%h bout=%b, required 0 0 00 0", busy, done, diff, bout);
      end
      tick(); tick();
      tests++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         fails++;
         $display("FAIL abort_idle: busy=%b done=%b, required 0 0", busy, done);
      end
      issue(8'h5A, 8'h3C, 1'b0);
      wait_done("abort_rerun");
      tests++;
      if (diff !== 8'h1E || bout !== 1'b0) begin
         fails++;
         $display("FAIL abort_rerun: diff=%h bout=%b, required 1e 0", diff, bout);
      end
      $display("[TB] rerun after abort: diff=%h bout=%b", diff, bout);
      tick();
   endtask

   // Inputs scrambled during RUN must not disturb the captured operands.
   task automatic test_random();
      logic [WIDTH-1:0] av, bv;
      logic             cv;
      logic [WIDTH:0]   expv;
      bit               seen;
      for (int n = 0; n < 1000; n++) begin
         av = WIDTH'($urandom);
         bv = WIDTH'($urandom);
         cv = 1'($urandom);
         expv = {1'b0, av} - {1'b0, bv} - {{WIDTH{1'b0}}, cv};
         issue(av, bv, cv);
         seen = 1'b0;
         for (int i = 0; i < 64; i++) begin
            if (done) begin
               seen = 1'b1;
               break;
            end
            a = WIDTH'($urandom); b = WIDTH'($urandom); bin = 1'($urandom);
            tick();
         end
         tests++;
         if (!seen || {bout, diff} !== expv) begin
            fails++;
            $display("FAIL random[%0d]: a=%h b=%h bin=%b seen=%b bout,diff=%h, required %h",
                     n, av, bv, cv, seen, {bout, diff}, expv);
         end
         if (n % 100 == 0)
            $display("[TB] random[%0d] %h-%h-%b: diff=%h bout=%b", n, av, bv, cv, diff, bout);
         tick();
      end
   endtask

`ifdef SUB_OVF_EN
   task automatic test_ovf();
      issue(8'h80, 8'h01, 1'b0);
      wait_done("ovf_wait1");
      tests++;
      if (diff !== 8'h7F || ovf !== 1'b1) begin
         fails++;
         $display("FAIL ovf_set: diff=%h ovf=%b, required 7f 1", diff, ovf);
      end
      $display("[TB] 80-01-0: diff=%h ovf=%b", diff, ovf);
      tick();
      issue(8'h7F, 8'h01, 1'b0);
      wait_done("ovf_wait2");
      tests++;
      if (diff !== 8'h7E || ovf !== 1'b0) begin
         fails++;
         $display("FAIL ovf_clear: diff=%h ovf=%b, required 7e 0", diff, ovf);
      end
      $display("[TB] 7f-01-0: diff=%h ovf=%b", diff, ovf);
      tick();
   endtask
`endif

   initial begin
      tests = 0;
      fails = 0;
      rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
      test_reset();
      test_basic();
      test_borrow();
      test_back_to_back();
      test_abort();
      test_random();
`ifdef SUB_OVF_EN
      test_ovf();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
